sa1_mmc_regs: RTL and testbench

SA1_MMC_REGS -- requirements
Module: sa1_mmc_regs

---
 rtl/sa1_mmc_regs.sv | 164 ++++++++++++++++
 tb/tb_sa1_mmc_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa1_mmc_regs.sv
// SA-1 MMC register file: captures SNES CPU writes to the bank-remap,
// BW-RAM block select and DMA control registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a synchronized falling edge of SNES_WR
// S_WAIT   | counting down until address/data are settled, then sample
// S_COMMIT | one cycle: decode the sampled address and update registers
// S_HOLD   | write done; wait for SNES_WR to return high
module sa1_mmc_regs #(
   parameter int unsigned WR_SAMPLE = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [23:0] SNES_ADDR,
   input  logic [7:0]  SNES_DATA,
   input  logic        SNES_WR,
   output logic [11:0] sa1_xxb,
   output logic [3:0]  sa1_xxb_en,
   output logic [4:0]  sa1_bmaps_sbm,
   output logic        sa1_dma_cc1_en,
   output logic        reg_we,
   output logic        reg_ignored
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_COMMIT = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0]  CNT_LOAD  = 4'(WR_SAMPLE - 1);
   localparam logic [11:0] XXB_RESET = 12'b011_010_001_000;

   logic        wr_s1_q, wr_s2_q, wr_s3_q;
   logic [1:0]  fill_q;
   logic        sync_ok, wr_fall, wr_rise;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [16:0] addr_q;
   logic [7:0]  data_q;
   logic [11:0] xxb_q;
   logic [3:0]  xxb_en_q;
   logic [4:0]  sbm_q;
   logic        cc1_q;
   logic        we_q;
   logic        ign_q;

   logic [3:0]  dec_xxb;
   logic        dec_bmaps, dec_dcnt, dec_cdma, dec_any;

   logic        unused_bits;
   assign unused_bits = ^{SNES_ADDR[23], SNES_ADDR[21:16], data_q[6]};

   // Synchronize SNES_WR; fill_q blocks edge detection until all three
   // stages hold real samples so a strobe already low at reset release
   // is not mistaken for a fresh falling edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_s1_q <= 1'b1;
         wr_s2_q <= 1'b1;
         wr_s3_q <= 1'b1;
         fill_q  <= 2'd0;
      end else begin
         wr_s1_q <= SNES_WR;
         wr_s2_q <= wr_s1_q;
         wr_s3_q <= wr_s2_q;
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      end
   end

   assign sync_ok = (fill_q == 2'd3);
   assign wr_fall = sync_ok &  wr_s3_q & ~wr_s2_q;
   assign wr_rise = sync_ok & ~wr_s3_q &  wr_s2_q;

   // Register decode from the sampled address (addr_q[16] holds SNES_ADDR[22]).
   always_comb begin
      dec_xxb   = 4'b0000;
      dec_bmaps = 1'b0;
      dec_dcnt  = 1'b0;
      dec_cdma  = 1'b0;
      if (!addr_q[16]) begin
         case (addr_q[15:0])
            16'h2220: dec_xxb   = 4'b0001;
            16'h2221: dec_xxb   = 4'b0010;
            16'h2222: dec_xxb   = 4'b0100;
            16'h2223: dec_xxb   = 4'b1000;
            16'h2224: dec_bmaps = 1'b1;
            16'h2230: dec_dcnt  = 1'b1;
            16'h2231: dec_cdma  = 1'b1;
            default: ;
         endcase
      end
      dec_any = (|dec_xxb) | dec_bmaps | dec_dcnt | dec_cdma;
   end

   // Write-strobe sequencer and the register file it commits into.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 17'd0;
         data_q   <= 8'd0;
         xxb_q    <= XXB_RESET;
         xxb_en_q <= 4'd0;
         sbm_q    <= 5'd0;
         cc1_q    <= 1'b0;
         we_q     <= 1'b0;
         ign_q    <= 1'b0;
      end else begin
         we_q  <= 1'b0;
         ign_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (wr_fall) begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               // An abort wins over a sample landing on the same cycle.
               if (wr_rise) begin
                  ign_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else if (cnt_q == 4'd0) begin
                  addr_q  <= {SNES_ADDR[22], SNES_ADDR[15:0]};
                  data_q  <= SNES_DATA;
                  state_q <= S_COMMIT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_COMMIT: begin
               for (int n = 0; n < 4; n++) begin
                  if (dec_xxb[n]) begin
                     xxb_q[3*n +: 3] <= data_q[2:0];
                     xxb_en_q[n]     <= data_q[7];
                  end
               end
               if (dec_bmaps) sbm_q <= data_q[4:0];
               if (dec_dcnt) cc1_q <= data_q[7] & data_q[5] & ~data_q[4];
               else if (dec_cdma && data_q[7]) cc1_q <= 1'b0;
               we_q    <= dec_any;
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               // Level check so a strobe that rose during COMMIT still releases.
               if (wr_s2_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sa1_xxb        = xxb_q;
   assign sa1_xxb_en     = xxb_en_q;
   assign sa1_bmaps_sbm  = sbm_q;
   assign sa1_dma_cc1_en = cc1_q;
   assign reg_we         = we_q;
   assign reg_ignored    = ign_q;

endmodule

// File: tb/tb_sa1_mmc_regs.sv
// Bench for sa1_mmc_regs: a write-level model predicts when each strobe
// commits or aborts and what the register file holds afterwards.
module tb_sa1_mmc_regs;

   localparam int W = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [23:0] SNES_ADDR = 24'd0;
   logic [7:0]  SNES_DATA = 8'd0;
   logic        SNES_WR = 1'b1;
   logic [11:0] sa1_xxb;
   logic [3:0]  sa1_xxb_en;
   logic [4:0]  sa1_bmaps_sbm;
   logic        sa1_dma_cc1_en;
   logic        reg_we;
   logic        reg_ignored;

   sa1_mmc_regs #(.WR_SAMPLE(W)) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .SNES_ADDR      (SNES_ADDR),
      .SNES_DATA      (SNES_DATA),
      .SNES_WR        (SNES_WR),
      .sa1_xxb        (sa1_xxb),
      .sa1_xxb_en     (sa1_xxb_en),
      .sa1_bmaps_sbm  (sa1_bmaps_sbm),
      .sa1_dma_cc1_en (sa1_dma_cc1_en),
      .reg_we         (reg_we),
      .reg_ignored    (reg_ignored)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_cnt = 0;
   int ign_cnt = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int          at;
      bit          commit;
      logic [23:0] a;
      logic [7:0]  d;
   } ev_t;

   ev_t q[$];

   logic [2:0] m_xb [4];
   logic       m_en [4];
   logic [4:0] m_sbm;
   logic       m_cc1;
   logic       m_we;
   logic       m_ign;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_xb[0] = 3'd0; m_xb[1] = 3'd1; m_xb[2] = 3'd2; m_xb[3] = 3'd3;
      for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
      m_sbm = 5'd0;
      m_cc1 = 1'b0;
   endtask

   // Apply one write to the register model; hit reports a decoded register.
   task automatic model_write(input logic [23:0] a, input logic [7:0] d, output bit hit);
      int idx;
      hit = 1'b0;
      if (a[22] == 1'b0) begin
         if (a[15:0] >= 16'h2220 && a[15:0] <= 16'h2223) begin
            idx = int'(a[15:0]) - 'h2220;
            m_xb[idx] = d[2:0];
            m_en[idx] = d[7];
            hit = 1'b1;
         end else if (a[15:0] == 16'h2224) begin
            m_sbm = d[4:0];
            hit = 1'b1;
         end else if (a[15:0] == 16'h2230) begin
            m_cc1 = d[7] && d[5] && !d[4];
            hit = 1'b1;
         end else if (a[15:0] == 16'h2231) begin
            if (d[7]) m_cc1 = 1'b0;
            hit = 1'b1;
         end
      end
   endtask

   initial model_reset();

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      ev_t e;
      bit  hit;
      m_we  = 1'b0;
      m_ign = 1'b0;
      if (!RST_N) begin
         model_reset();
         q.delete();
      end else begin
         while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at == cyc) begin
               if (e.commit) begin
                  model_write(e.a, e.d, hit);
                  m_we = hit;
               end else begin
                  m_ign = 1'b1;
               end
            end
         end
      end
      check("xxb", 32'(sa1_xxb), 32'({m_xb[3], m_xb[2], m_xb[1], m_xb[0]}));
      check("xxb_en", 32'(sa1_xxb_en), 32'({m_en[3], m_en[2], m_en[1], m_en[0]}));
      check("bmaps_sbm", 32'(sa1_bmaps_sbm), 32'(m_sbm));
      check("dma_cc1_en", 32'(sa1_dma_cc1_en), 32'(m_cc1));
      check("reg_we", 32'(reg_we), 32'(m_we));
      check("reg_ignored", 32'(reg_ignored), 32'(m_ign));
      if (RST_N && reg_we) we_cnt++;
      if (RST_N && reg_ignored) ign_cnt++;
   end

   // Strobe held low for lo sampled cycles, then high for hi cycles.
   // Commits iff lo > W: visible 3+W cycles after the first low sample;
   // otherwise reg_ignored pulses 2 cycles after the first high sample.
   task automatic do_write(input logic [23:0] a, input logic [7:0] d, input int lo, input int hi);
      ev_t e;
      int  k;
      @(negedge CLK); #1;
      SNES_ADDR = a;
      SNES_DATA = d;
      SNES_WR   = 1'b0;
      k = cyc + 1;
      e.a = a;
      e.d = d;
      if (lo > W) begin
         e.commit = 1'b1;
         e.at     = k + 3 + W;
      end else begin
         e.commit = 1'b0;
         e.at     = k + lo + 2;
      end
      q.push_back(e);
      repeat (lo) @(negedge CLK);
      #1 SNES_WR = 1'b1;
      repeat (hi - 1) @(negedge CLK);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   int we0, ign0;

   initial begin
      idle(3);
      check("rst_xxb", 32'(sa1_xxb), 32'h688);
      check("rst_en", 32'(sa1_xxb_en), 32'h0);
      check("rst_sbm", 32'(sa1_bmaps_sbm), 32'h0);
      check("rst_cc1", 32'(sa1_dma_cc1_en), 32'h0);
      #1 RST_N = 1'b1;
      idle(6);

      we0 = we_cnt;
      do_write(24'h002220, 8'h85, 10, 3);
      idle(4);
      check("cxb_write_xxb", 32'(sa1_xxb), 32'h68D);
      check("cxb_write_en", 32'(sa1_xxb_en), 32'h1);
      check("cxb_write_we_count", 32'(we_cnt - we0), 32'd1);

      do_write(24'h802224, 8'hFF, 10, 3);
      idle(4);
      check("bmaps_80", 32'(sa1_bmaps_sbm), 32'h1F);
      we0 = we_cnt;
      do_write(24'h402224, 8'h01, 10, 3);
      idle(4);
      check("bmaps_40_ignored", 32'(sa1_bmaps_sbm), 32'h1F);
      check("bmaps_40_no_we", 32'(we_cnt - we0), 32'd0);

      do_write(24'h002230, 8'hA0, 10, 3);
      idle(4);
      check("dcnt_a0", 32'(sa1_dma_cc1_en), 32'd1);
      do_write(24'h002231, 8'h00, 10, 3);
      idle(4);
      check("cdma_00_keeps", 32'(sa1_dma_cc1_en), 32'd1);
      do_write(24'h002231, 8'h80, 10, 3);
      idle(4);
      check("cdma_80_clears", 32'(sa1_dma_cc1_en), 32'd0);
      do_write(24'h002230, 8'hA0, 10, 3);
      do_write(24'h002230, 8'hB0, 10, 3);
      idle(4);
      check("dcnt_b0", 32'(sa1_dma_cc1_en), 32'd0);

      we0 = we_cnt; ign0 = ign_cnt;
      do_write(24'h002220, 8'h02, 3, 3);
      idle(5);
      check("short3_ign", 32'(ign_cnt - ign0), 32'd1);
      check("short3_no_we", 32'(we_cnt - we0), 32'd0);
      check("short3_xxb", 32'(sa1_xxb), 32'h68D);
      do_write(24'h002220, 8'h02, W, 3);
      idle(5);
      check("edge_w_ign", 32'(ign_cnt - ign0), 32'd2);
      do_write(24'h002220, 8'h02, W + 1, 3);
      idle(5);
      check("edge_w1_xxb", 32'(sa1_xxb), 32'h68A);
      check("edge_w1_en", 32'(sa1_xxb_en), 32'h0);

      we0 = we_cnt;
      do_write(24'h002225, 8'hFF, 10, 3);
      idle(4);
      check("unmapped_no_we", 32'(we_cnt - we0), 32'd0);
      do_write(24'hBF2223, 8'h81, 10, 3);
      idle(4);
      check("bank_dc_xxb", 32'(sa1_xxb), 32'h28A);
      check("bank_dc_en", 32'(sa1_xxb_en), 32'h8);

      we0 = we_cnt; ign0 = ign_cnt;
      @(negedge CLK); #1;
      SNES_ADDR = 24'h002223;
      SNES_DATA = 8'h87;
      SNES_WR   = 1'b0;
      repeat (4) @(negedge CLK);
      #1 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      #1 RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      #1 SNES_WR = 1'b1;
      idle(6);
      check("rstwait_fxb", 32'(sa1_xxb[11:9]), 32'd3);
      check("rstwait_xxb", 32'(sa1_xxb), 32'h688);
      check("rstwait_en", 32'(sa1_xxb_en), 32'h0);
      check("rstwait_no_we", 32'(we_cnt - we0), 32'd0);
      check("rstwait_no_ign", 32'(ign_cnt - ign0), 32'd0);

      we0 = we_cnt;
      do_write(24'h002221, 8'h84, 10, 2);
      do_write(24'h002222, 8'h86, 10, 5);
      idle(4);
      check("b2b_xxb", 32'(sa1_xxb), 32'h7A0);
      check("b2b_en", 32'(sa1_xxb_en), 32'h6);
      check("b2b_we_count", 32'(we_cnt - we0), 32'd2);

      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
